// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer, its time chain,
// the tick counter instance and the benches.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_LAP    = 2'd2,
      ST_PAUSED = 2'd3
   } state_e;

   localparam logic [3:0]  TENTH_MAX = 4'd9;
   localparam logic [5:0]  SEC_MAX   = 6'd59;
   // 100 ms at 50 MHz: the tick counter pulses when it reaches this value.
   localparam logic [31:0] TICK_TC   = 32'd4_999_999;

endpackage

// File: rtl/stopwatch_time_chain.sv
// Live elapsed-time registers: tenths -> seconds -> minutes cascade.
// Exposes both the current value and the value to be loaded at the next edge.
module stopwatch_time_chain
   import stopwatch_pkg::*;
#(
   parameter int P_MAX_MIN = 59,
   parameter int P_MIN_W   = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_inc,
   input  logic               i_clr,
   output logic [P_MIN_W-1:0] o_min_d,
   output logic [5:0]         o_sec_d,
   output logic [3:0]         o_tenth_d,
   output logic [P_MIN_W-1:0] o_min,
   output logic [5:0]         o_sec,
   output logic [3:0]         o_tenth,
   output logic               o_wrap
);

   localparam logic [P_MIN_W-1:0] MIN_MAX = P_MAX_MIN[P_MIN_W-1:0];

   logic [P_MIN_W-1:0] min_q,   min_d;
   logic [5:0]         sec_q,   sec_d;
   logic [3:0]         tenth_q, tenth_d;
   logic               wrap_d;

   always_comb begin
      min_d   = min_q;
      sec_d   = sec_q;
      tenth_d = tenth_q;
      wrap_d  = 1'b0;
      if (i_clr) begin
         min_d   = '0;
         sec_d   = '0;
         tenth_d = '0;
      end else if (i_inc) begin
         if (tenth_q == TENTH_MAX) begin
            tenth_d = '0;
            if (sec_q == SEC_MAX) begin
               sec_d = '0;
               if (min_q == MIN_MAX) begin
                  min_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  min_d = min_q + 1'b1;
               end
            end else begin
               sec_d = sec_q + 1'b1;
            end
         end else begin
            tenth_d = tenth_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         min_q   <= '0;
         sec_q   <= '0;
         tenth_q <= '0;
      end else begin
         min_q   <= min_d;
         sec_q   <= sec_d;
         tenth_q <= tenth_d;
      end
   end

   assign o_min_d   = min_d;
   assign o_sec_d   = sec_d;
   assign o_tenth_d = tenth_d;
   assign o_min     = min_q;
   assign o_sec     = sec_q;
   assign o_tenth   = tenth_q;
   assign o_wrap    = wrap_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/lap/reset FSM, tick counter enable,
// lap-freezable display registers and sticky overflow flag.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int P_MAX_MIN = 59,
   parameter int P_MIN_W   = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start_stop,
   input  logic               i_lap_reset,
   input  logic               i_tick,
   output logic               o_cnt_enable,
   output logic [P_MIN_W-1:0] o_min,
   output logic [5:0]         o_sec,
   output logic [3:0]         o_tenth,
   output logic [1:0]         o_state,
   output logic               o_overflow
);

   state_e             state_q, state_d;
   logic               running;
   logic               live_inc, live_clr, live_wrap;
   logic [P_MIN_W-1:0] live_min_d,   live_min;
   logic [5:0]         live_sec_d,   live_sec;
   logic [3:0]         live_tenth_d, live_tenth;
   logic [P_MIN_W-1:0] disp_min_q;
   logic [5:0]         disp_sec_q;
   logic [3:0]         disp_tenth_q;
   logic               disp_load;
   logic               overflow_q;

   assign running  = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign live_inc = running && i_tick;
   // L in PAUSED is the only path back to IDLE besides reset.
   assign live_clr = (state_q == ST_PAUSED) && !i_start_stop && i_lap_reset;

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (i_start_stop)     state_d = ST_RUN;
         ST_RUN:    if (i_start_stop)     state_d = ST_PAUSED;
                    else if (i_lap_reset) state_d = ST_LAP;
         ST_LAP:    if (i_start_stop)     state_d = ST_PAUSED;
                    else if (i_lap_reset) state_d = ST_RUN;
         ST_PAUSED: if (i_start_stop)     state_d = ST_RUN;
                    else if (i_lap_reset) state_d = ST_IDLE;
         default:                         state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_cnt_enable = running;
      o_state      = state_q;
   end

   stopwatch_time_chain #(
      .P_MAX_MIN (P_MAX_MIN),
      .P_MIN_W   (P_MIN_W)
   ) u_live (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_inc     (live_inc),
      .i_clr     (live_clr),
      .o_min_d   (live_min_d),
      .o_sec_d   (live_sec_d),
      .o_tenth_d (live_tenth_d),
      .o_min     (live_min),
      .o_sec     (live_sec),
      .o_tenth   (live_tenth),
      .o_wrap    (live_wrap)
   );

   // Hold only while staying in LAP; entering LAP captures the post-tick value.
   assign disp_load = !((state_q == ST_LAP) && (state_d == ST_LAP));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         disp_min_q   <= '0;
         disp_sec_q   <= '0;
         disp_tenth_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         if (disp_load) begin
            disp_min_q   <= live_min_d;
            disp_sec_q   <= live_sec_d;
            disp_tenth_q <= live_tenth_d;
         end
         if (live_clr)       overflow_q <= 1'b0;
         else if (live_wrap) overflow_q <= 1'b1;
      end
   end

   assign o_min      = disp_min_q;
   assign o_sec      = disp_sec_q;
   assign o_tenth    = disp_tenth_q;
   assign o_overflow = overflow_q;

   // Live current value is kept visible for hierarchy probing in lab bring-up.
   logic unused_live;
   assign unused_live = ^{live_min, live_sec, live_tenth};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: elapsed time modelled as a total count
// of tenths, compared against the DUT every cycle, plus literal spot checks.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int MAXMIN = 59;
   localparam int MINW   = 6;
   localparam int LIMIT  = (MAXMIN + 1) * 600;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            s = 1'b0, l = 1'b0, t = 1'b0;
   logic            cnt_en;
   logic [MINW-1:0] d_min;
   logic [5:0]      d_sec;
   logic [3:0]      d_tenth;
   logic [1:0]      d_state;
   logic            d_ovf;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model: mode 0 idle, 1 run, 2 lap, 3 paused; times are totals in tenths.
   int m_mode = 0;
   int m_live = 0;
   int m_disp = 0;
   bit m_ovf  = 1'b0;

   stopwatch_ctrl #(.P_MAX_MIN(MAXMIN), .P_MIN_W(MINW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start_stop (s),
      .i_lap_reset  (l),
      .i_tick       (t),
      .o_cnt_enable (cnt_en),
      .o_min        (d_min),
      .o_sec        (d_sec),
      .o_tenth      (d_tenth),
      .o_state      (d_state),
      .o_overflow   (d_ovf)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      int nm;
      if (rst) begin
         m_mode = 0; m_live = 0; m_disp = 0; m_ovf = 1'b0;
      end else begin
         if ((m_mode == 1 || m_mode == 2) && t) begin
            m_live = m_live + 1;
            if (m_live == LIMIT) begin
               m_live = 0;
               m_ovf  = 1'b1;
            end
         end
         nm = m_mode;
         if (s)      nm = (m_mode == 0 || m_mode == 3) ? 1 : 3;
         else if (l) begin
            if (m_mode == 1)      nm = 2;
            else if (m_mode == 2) nm = 1;
            else if (m_mode == 3) begin
               nm = 0; m_live = 0; m_ovf = 1'b0;
            end
         end
         if (!(m_mode == 2 && nm == 2)) m_disp = m_live;
         m_mode = nm;
      end
   end

   always @(negedge clk) begin
      int exp_min, exp_sec, exp_tenth;
      if (chk_en) begin
         exp_min   = m_disp / 600;
         exp_sec   = (m_disp / 10) % 60;
         exp_tenth = m_disp % 10;
         checks = checks + 1;
         if (int'(d_min) != exp_min || int'(d_sec) != exp_sec || int'(d_tenth) != exp_tenth ||
             int'(d_state) != m_mode || cnt_en != (m_mode == 1 || m_mode == 2) || d_ovf != m_ovf) begin
            errors = errors + 1;
            if (errors <= 20)
               $display("FAIL cycle_model @%0t: got %0d:%0d.%0d st=%0d en=%0b ovf=%0b, expected %0d:%0d.%0d st=%0d en=%0b ovf=%0b",
                        $time, d_min, d_sec, d_tenth, d_state, cnt_en, d_ovf,
                        exp_min, exp_sec, exp_tenth, m_mode, (m_mode == 1 || m_mode == 2), m_ovf);
         end
      end
   end

   // Drive inputs just after a falling edge, hold through one rising edge.
   task automatic step(input logic sv, input logic lv, input logic tv);
      s = sv; l = lv; t = tv;
      @(negedge clk);
      s = 1'b0; l = 1'b0; t = 1'b0;
   endtask

   task automatic ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b1);
         repeat (gap) step(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic expect_lit(input string name, input int min_e, input int sec_e, input int ten_e,
                             input int st_e, input int en_e, input int ovf_e);
      checks = checks + 1;
      if (int'(d_min) != min_e || int'(d_sec) != sec_e || int'(d_tenth) != ten_e ||
          int'(d_state) != st_e || int'(cnt_en) != en_e || int'(d_ovf) != ovf_e) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d:%0d.%0d st=%0d en=%0b ovf=%0b, expected %0d:%0d.%0d st=%0d en=%0d ovf=%0d",
                  name, d_min, d_sec, d_tenth, d_state, cnt_en, d_ovf,
                  min_e, sec_e, ten_e, st_e, en_e, ovf_e);
      end else begin
         $display("check %s: %0d:%0d.%0d st=%0d en=%0b ovf=%0b", name,
                  d_min, d_sec, d_tenth, d_state, cnt_en, d_ovf);
      end
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk_en = 1'b1;
      expect_lit("reset", 0, 0, 0, 0, 0, 0);

      // Start, then 25 ticks spaced 10 cycles.
      step(1'b0, 1'b1, 1'b1);
      expect_lit("idle_ignores_L_tick", 0, 0, 0, 0, 0, 0);
      step(1'b1, 1'b0, 1'b0);
      expect_lit("enable_after_S", 0, 0, 0, 1, 1, 0);
      ticks(25, 9);
      expect_lit("run_25_ticks", 0, 2, 5, 1, 1, 0);

      // Lap freeze at 00:03.4, 20 more ticks, release.
      ticks(9, 2);
      step(1'b0, 1'b1, 1'b0);
      expect_lit("lap_freeze", 0, 3, 4, 2, 1, 0);
      ticks(20, 3);
      expect_lit("lap_held", 0, 3, 4, 2, 1, 0);
      step(1'b0, 1'b1, 1'b0);
      expect_lit("lap_release", 0, 5, 4, 1, 1, 0);

      // Pause coinciding with a tick at 00:00.9.
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      ticks(9, 1);
      expect_lit("at_0_9", 0, 0, 9, 1, 1, 0);
      step(1'b1, 1'b0, 1'b1);
      expect_lit("pause_with_tick", 0, 1, 0, 3, 0, 0);
      ticks(5, 1);
      expect_lit("paused_ignores_ticks", 0, 1, 0, 3, 0, 0);

      // S and L together from PAUSED: S wins.
      step(1'b1, 1'b1, 1'b0);
      expect_lit("s_wins", 0, 1, 0, 1, 1, 0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      expect_lit("to_idle", 0, 0, 0, 0, 0, 0);

      // Overflow wrap past 59:59.9, sticky across pause/resume.
      step(1'b1, 1'b0, 1'b0);
      ticks(LIMIT - 1, 0);
      expect_lit("at_max", 59, 59, 9, 1, 1, 0);
      ticks(1, 0);
      expect_lit("wrap", 0, 0, 0, 1, 1, 1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(3, 1);
      expect_lit("ovf_sticky", 0, 0, 3, 1, 1, 1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      expect_lit("ovf_clear_idle", 0, 0, 0, 0, 0, 0);

      // Reset in LAP at 12:34.5.
      step(1'b1, 1'b0, 1'b0);
      ticks(7545, 0);
      step(1'b0, 1'b1, 1'b0);
      expect_lit("lap_12_34_5", 12, 34, 5, 2, 1, 0);
      ticks(4, 1);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      expect_lit("reset_mid_lap", 0, 0, 0, 0, 0, 0);
      step(1'b1, 1'b0, 1'b0);
      expect_lit("restart", 0, 0, 0, 1, 1, 0);

      // Tick on the RUN-to-LAP edge is captured in the frozen display.
      step(1'b0, 1'b1, 1'b1);
      expect_lit("lap_with_tick", 0, 0, 1, 2, 1, 0);
      ticks(2, 1);
      step(1'b1, 1'b0, 1'b0);
      expect_lit("lap_to_pause_live", 0, 0, 3, 3, 0, 0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Stopwatch sequencer for the 100 ms tick counter: 32-bit counter, 50 MHz clock, terminal count 4,999,999.
- Drives the counter's enable, which also acts as its synchronous clear.
- Consumes the counter's one-cycle tick pulse and accumulates elapsed time as minutes/seconds/tenths.
- Implements start/stop/lap/reset from two debounced, single-cycle button pulses; feeds the display driver.

Parameters:
- P_MAX_MIN, 59: highest minute value before wrap to 00:00.0.
- P_MIN_W, 6: width of the minutes field; must hold P_MAX_MIN.

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  reset, synchronous, active-high; one clock only.
- i_start_stop  in  1  single-cycle pulse from debounced button A.
- i_lap_reset  in  1  single-cycle pulse from debounced button B.
- i_tick  in  1  single-cycle pulse from the tick counter, once per 100 ms while that counter is enabled.
- o_cnt_enable  out  1  enable to the tick counter; low holds the counter at zero.
- o_min  out  P_MIN_W  displayed minutes, 0..P_MAX_MIN.
- o_sec  out  6  displayed seconds, 0..59.
- o_tenth  out  4  displayed tenths, 0..9.
- o_state  out  2  current FSM state encoding.
- o_overflow  out  1  sticky flag: elapsed time wrapped past P_MAX_MIN:59.9.

Behaviour:
- Reset (i_rst high at an edge):
  - State becomes IDLE; live time and display registers are cleared to 0.
  - o_cnt_enable=0, o_overflow=0, o_state=IDLE.
  - Reset overrides every other input in that cycle, including mid-run.
- States and encoding: IDLE=0, RUN=1, LAP=2, PAUSED=3.
- o_cnt_enable is decoded from the state register: 1 in RUN or LAP, else 0.
  - It rises the cycle after the start pulse is sampled.
  - The sub-tick fraction is discarded on every pause; the counter restarts from 0 on resume. This is accepted.
- Transitions (S = i_start_stop, L = i_lap_reset):
  - IDLE: S goes to RUN. L is ignored.
  - RUN: S goes to PAUSED. L goes to LAP and freezes the display at the live value of that edge.
  - LAP: S goes to PAUSED and unfreezes the display, which shows live time. L goes to RUN and unfreezes.
  - PAUSED: S goes to RUN. L goes to IDLE and clears live time, display and o_overflow.
- Simultaneous S and L: S wins and L is dropped.
- Time accumulation: i_tick increments live time only when the current state is RUN or LAP.
  - A tick coinciding with a RUN/LAP-to-PAUSED transition is still counted.
  - Ticks in IDLE or PAUSED are ignored.
- Cascade:
  - tenth 9 + tick gives 0 and carries into sec.
  - sec 59 + carry gives 0 and carries into min.
  - min P_MAX_MIN + carry gives 0 and sets o_overflow.
- o_overflow stays set until IDLE entry or reset. Time keeps running after the wrap.
- Display registers:
  - When not frozen, they load the next live value on the same edge as the live registers, so a tick sampled at edge k is visible on o_* right after edge k.
  - When frozen (LAP), o_* hold while live time continues to advance.
- A tick in the same cycle as RUN-to-LAP counts. The frozen display captures the post-increment value.
- All outputs are registered or decoded directly from registers. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package stopwatch_pkg holds:
  - The state enum and its encodings.
  - TENTH_MAX=9 and SEC_MAX=59.
  - The 100 ms tick terminal count 4,999,999 as a named constant, for benches and the counter instance.
- Sub-module stopwatch_time_chain: tenth/sec/min cascade.
  - Inputs: inc, clr.
  - Outputs: next and current values, wrap.
  - Instantiated once for live time. The freeze register and mux stay in stopwatch_ctrl.

Test Plan:
- Reset, then S pulse, then 25 ticks spaced 10 cycles apart -> o_cnt_enable=1 the cycle after S; o_sec=2, o_tenth=5, o_state=RUN.
- In RUN at 00:03.4, L pulse, then 20 ticks -> o_* frozen at 00:03.4; L again -> o_* shows 00:05.4, state RUN.
- S in the same cycle as a tick at 00:00.9 -> state PAUSED, time 00:01.0, o_cnt_enable=0; further ticks ignored.
- PAUSED, then S and L in the same cycle -> state RUN with time retained; then S, then L -> IDLE with all outputs 0.
- Preload to 59:59.9 via ticks (or force), then one tick -> 00:00.0, o_overflow=1; stays set across pause/resume; clears on IDLE entry.
- i_rst asserted for 1 cycle in LAP at 12:34.5 -> all outputs 0, state IDLE, next S restarts from 00:00.0.
